// File: rtl/fpu_issue_ctrl.sv
// In-order issue controller for the 4-stage FPU: holds any instruction whose FP source
// register is still in flight, flags unsupported opcodes, and counts stall cycles.
module fpu_issue_ctrl #(
  parameter int unsigned PIPE_DEPTH   = 4,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned RegW   = 5;
  localparam int unsigned InstrW = 32;

  logic [RegW-1:0] rs1_c, rs2_c, rs3_c, rd_c, op_c, funct5_c;
  logic            is_r4_c, is_opfp_c, f5_ok_c, illegal_c;
  logic            use_rs1_c, use_rs2_c, use_rs3_c;
  logic            hazard_c, xfer_c;

  logic [PIPE_DEPTH-1:0]           trk_vld_q, trk_vld_d;
  logic [PIPE_DEPTH-1:0][RegW-1:0] trk_rd_q, trk_rd_d;
  logic                            issue_valid_q, issue_valid_d;
  logic [InstrW-1:0]               issue_instr_q, issue_instr_d;
  logic                            illegal_q, illegal_d;
  logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;

  // fmt, rm and the low opcode bits do not affect issue decisions
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[26:25], in_instr[14:12], in_instr[3:0]};

  // Field extraction and source-usage decode
  always_comb begin
    rs1_c     = in_instr[19:15];
    rs2_c     = in_instr[24:20];
    rs3_c     = in_instr[31:27];
    rd_c      = in_instr[11:7];
    op_c      = in_instr[6:2];
    funct5_c  = in_instr[31:27];
    is_r4_c   = (op_c[4:2] == 3'b100);
    is_opfp_c = (op_c[4:2] == 3'b101);
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    use_rs3_c = 1'b0;
    f5_ok_c   = 1'b0;

    case (funct5_c)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b01011, 5'b10100, 5'b11000, 5'b11010, 5'b11100, 5'b11110: f5_ok_c = 1'b1;
      default: f5_ok_c = 1'b0;
    endcase

    if (is_r4_c) begin
      use_rs1_c = 1'b1;
      use_rs2_c = 1'b1;
      use_rs3_c = 1'b1;
    end else if (is_opfp_c) begin
      use_rs1_c = 1'b1;
      use_rs2_c = 1'b1;
      case (funct5_c)
        5'b01011, 5'b11100, 5'b11000: use_rs2_c = 1'b0;
        5'b11010, 5'b11110: begin
          use_rs1_c = 1'b0;
          use_rs2_c = 1'b0;
        end
        default: ;
      endcase
    end

    illegal_c = ~(is_r4_c | (is_opfp_c & f5_ok_c));
  end

  // RAW check against every destination still in flight (f0 included)
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (trk_vld_q[i] &&
          ((use_rs1_c && (rs1_c == trk_rd_q[i])) ||
           (use_rs2_c && (rs2_c == trk_rd_q[i])) ||
           (use_rs3_c && (rs3_c == trk_rd_q[i])))) begin
        hazard_c = 1'b1;
      end
    end
  end

  assign in_ready = ~hazard_c | ~in_valid;
  assign xfer_c   = in_valid & in_ready;

  // Next-state: issue register, tracker shift and saturating stall counter
  always_comb begin
    issue_valid_d = xfer_c;
    issue_instr_d = xfer_c ? in_instr : BUBBLE_INSTR;
    illegal_d     = xfer_c & illegal_c;
    trk_vld_d     = {trk_vld_q[PIPE_DEPTH-2:0], xfer_c & ~illegal_c};
    trk_rd_d      = {trk_rd_q[PIPE_DEPTH-2:0], rd_c};
    stall_cnt_d   = stall_cnt_q;
    if (in_valid && hazard_c && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_instr_q <= BUBBLE_INSTR;
      illegal_q     <= 1'b0;
      trk_vld_q     <= '0;
      trk_rd_q      <= '0;
      stall_cnt_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      illegal_q     <= illegal_d;
      trk_vld_q     <= trk_vld_d;
      trk_rd_q      <= trk_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_instr = issue_instr_q;
  assign illegal     = illegal_q;
  assign busy        = |trk_vld_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: default instance plus a CNT_W=4 instance for saturation.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;

  logic        in_ready, issue_valid, illegal, busy;
  logic [31:0] issue_instr;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_issue_valid, s_illegal, s_busy;
  logic [31:0] s_issue_instr;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .illegal(illegal), .busy(busy), .stall_cnt(stall_cnt)
  );

  fpu_issue_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(s_in_ready), .issue_valid(s_issue_valid), .issue_instr(s_issue_instr),
    .illegal(s_illegal), .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [31:0] fp_r(input logic [4:0] f5, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f5, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] fp_r4(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rs3);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1000011};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_instr = 32'h0;
    rst_n    = 1'b0;
    #3;
    rst_n    = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] fmul;
    do_reset();
    n_checks++;
    if (issue_valid !== 1'b0 || issue_instr !== 32'h0 || busy !== 1'b0 || stall_cnt !== 16'd0 || illegal !== 1'b0)
      $display("FAIL reset_idle: iv=%b ii=%h busy=%b cnt=%0d ill=%b, expected 0/0/0/0/0",
               issue_valid, issue_instr, busy, stall_cnt, illegal);
    else n_pass++;

    in_valid = 1'b1;
    in_instr = fp_r(5'b00000, 5'd1, 5'd2, 5'd3);
    cyc();
    in_instr = fp_r(5'b00001, 5'd7, 5'd1, 5'd2);
    cyc();
    fmul = fp_r(5'b00010, 5'd4, 5'd5, 5'd6);
    in_instr = fmul;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== fmul || busy !== 1'b1 || stall_cnt !== 16'd1)
      $display("FAIL reset_pre: iv=%b ii=%h busy=%b cnt=%0d, expected 1/%h/1/1",
               issue_valid, issue_instr, busy, stall_cnt, fmul);
    else n_pass++;

    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (issue_valid !== 1'b0 || issue_instr !== 32'h0 || busy !== 1'b0 || stall_cnt !== 16'd0)
      $display("FAIL reset_async: iv=%b ii=%h busy=%b cnt=%0d, expected 0/0/0/0",
               issue_valid, issue_instr, busy, stall_cnt);
    else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] fadd, fmul;
    do_reset();
    fadd = fp_r(5'b00000, 5'd1, 5'd2, 5'd3);
    fmul = fp_r(5'b00010, 5'd4, 5'd5, 5'd6);
    in_valid = 1'b1;
    in_instr = fadd;
    #0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b expected 1", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== fadd || busy !== 1'b1)
      $display("FAIL b2b_issue0: iv=%b ii=%h busy=%b, expected 1/%h/1", issue_valid, issue_instr, busy, fadd);
    else n_pass++;
    in_instr = fmul;
    #0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b expected 1", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== fmul || busy !== 1'b1)
      $display("FAIL b2b_issue1: iv=%b ii=%h busy=%b, expected 1/%h/1", issue_valid, issue_instr, busy, fmul);
    else n_pass++;
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b0 || issue_instr !== 32'h0)
      $display("FAIL b2b_bubble: iv=%b ii=%h, expected 0/0", issue_valid, issue_instr);
    else n_pass++;
    repeat (4) cyc();
    n_checks++;
    if (busy !== 1'b0 || stall_cnt !== 16'd0)
      $display("FAIL b2b_drain: busy=%b cnt=%0d, expected 0/0", busy, stall_cnt);
    else n_pass++;
  endtask

  // Producer transfers, then consumer must see exactly 4 stalled cycles before issuing
  task automatic run_dependent(input string tag, input logic [31:0] prod, input logic [31:0] cons);
    int stalls;
    in_valid = 1'b1;
    in_instr = prod;
    cyc();
    in_instr = cons;
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      #0;
      if (in_ready) break;
      stalls++;
      cyc();
      n_checks++;
      if (issue_valid !== 1'b0)
        $display("FAIL %s_stall_bubble: iv=%b at stall %0d, expected 0", tag, issue_valid, stalls);
      else n_pass++;
    end
    n_checks++;
    if (stalls != 4) $display("FAIL %s_stall_len: got %0d cycles expected 4", tag, stalls);
    else n_pass++;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== cons)
      $display("FAIL %s_issue: iv=%b ii=%h, expected 1/%h", tag, issue_valid, issue_instr, cons);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_raw_rs1();
    do_reset();
    run_dependent("raw_rs1", fp_r(5'b00000, 5'd1, 5'd2, 5'd3), fp_r(5'b00001, 5'd7, 5'd1, 5'd2));
    n_checks++;
    if (stall_cnt !== 16'd4) $display("FAIL raw_rs1_cnt: got %0d expected 4", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_r4_rs3();
    logic [31:0] fsqrt;
    do_reset();
    run_dependent("r4_rs3", fp_r(5'b00010, 5'd9, 5'd2, 5'd3), fp_r4(5'd10, 5'd4, 5'd5, 5'd9));
    repeat (5) cyc();
    in_valid = 1'b1;
    in_instr = fp_r(5'b00010, 5'd9, 5'd2, 5'd3);
    cyc();
    fsqrt = fp_r(5'b01011, 5'd11, 5'd4, 5'd9);
    in_instr = fsqrt;
    #0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL fsqrt_rs2_ignored: ready=%b expected 1", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== fsqrt)
      $display("FAIL fsqrt_issue: iv=%b ii=%h, expected 1/%h", issue_valid, issue_instr, fsqrt);
    else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] bad, rdr;
    do_reset();
    bad = fp_r(5'b01111, 5'd12, 5'd1, 5'd2);
    rdr = fp_r(5'b00000, 5'd13, 5'd12, 5'd12);
    in_valid = 1'b1;
    in_instr = bad;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== bad || illegal !== 1'b1 || busy !== 1'b0)
      $display("FAIL illegal_issue: iv=%b ii=%h ill=%b busy=%b, expected 1/%h/1/0",
               issue_valid, issue_instr, illegal, busy, bad);
    else n_pass++;
    in_instr = rdr;
    #0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL illegal_no_track: ready=%b expected 1", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== rdr || illegal !== 1'b0 || busy !== 1'b1)
      $display("FAIL illegal_follow: iv=%b ii=%h ill=%b busy=%b, expected 1/%h/0/1",
               issue_valid, issue_instr, illegal, busy, rdr);
    else n_pass++;
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if (illegal !== 1'b0) $display("FAIL illegal_pulse: ill=%b expected 0", illegal);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      run_dependent("sat", fp_r(5'b00000, 5'd1, 5'd2, 5'd3), fp_r(5'b00001, 5'd7, 5'd1, 5'd2));
    end
    n_checks++;
    if (s_stall_cnt !== 4'hF) $display("FAIL sat_cnt4: got %h expected f", s_stall_cnt);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd20) $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt);
    else n_pass++;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    test_reset();
    test_back_to_back();
    test_raw_rs1();
    test_r4_rs3();
    test_illegal();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
